lsq_issue_scheduler: RTL
========================

LSQ_ISSUE_SCHEDULER -- requirements
Module: lsq_issue_scheduler

Interface
REQ-001 SHALL have parameter NUM_SUBUNITS, default 3, number of memory subunits (local mem, bus, cache); SW = max(1, clog2(NUM_SUBUNITS)).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, limit on in-flight loads; CW = clog2(MAX_OUTSTANDING+1).
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, consecutive load wins before a store is forced.
REQ-004 SHALL have ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_valid  in  1  load queue head ready to issue.
- load_subunit  in  SW  subunit of load head.
- store_valid  in  1  store queue head ready to issue.
- store_subunit  in  SW  subunit of store head.
- subunit_ready  in  NUM_SUBUNITS  per-subunit accept.
- load_response  in  1  one load result returned this cycle.
- sq_empty  in  1  store queue empty.
- fence_req  in  1  level request to drain memory ops.
- load_pop  out  1  issue and pop load head.
- store_pop  out  1  issue and pop store head.
- issue_sel  out  NUM_SUBUNITS  one-hot target subunit of the issue, all-zero if none.
- outstanding  out  CW  in-flight load count.
- fence_ack  out  1  one-cycle drain-complete pulse.

Function
REQ-005 load_pop, store_pop and issue_sel SHALL be combinational, with zero-cycle latency from inputs and registered state.
REQ-006 load_pop and store_pop SHALL never both be 1.
REQ-007 load_ok SHALL be: load_valid & subunit_ready[load_subunit] & outstanding<MAX_OUTSTANDING & (outstanding==0 | load_subunit==last_sub) & state==NORMAL. This preserves in-order responses across subunits.
REQ-008 store_ok SHALL be: store_valid & subunit_ready[store_subunit], in any state.
REQ-009 States SHALL be NORMAL, STORE_FORCE and DRAIN, each held in a registered state variable.
REQ-010 In NORMAL: load_pop=load_ok; store_pop=store_ok & ~load_ok. Loads have priority.
REQ-011 In STORE_FORCE: store_pop=store_ok; load_pop=0.
REQ-012 In DRAIN: store_pop=store_ok; load_pop=0.
REQ-013 starve_cnt SHALL increment when store_ok & load_pop, saturating at STARVE_LIMIT. It SHALL clear on store_pop or ~store_valid.
REQ-014 NORMAL->STORE_FORCE SHALL occur when starve_cnt==STARVE_LIMIT at the clock edge and fence_req==0.
REQ-015 STORE_FORCE->NORMAL SHALL occur on the cycle after store_pop, or on ~store_valid.
REQ-016 NORMAL or STORE_FORCE->DRAIN SHALL occur when fence_req==1. This has priority over REQ-014 and REQ-015.
REQ-017 In DRAIN, when sq_empty & outstanding==0 & ~store_pop: fence_ack=1 for exactly one cycle (registered), then the state SHALL go to NORMAL. DRAIN SHALL hold until ack even if fence_req drops.
REQ-018 fence_req still high in the cycle after fence_ack SHALL start a new DRAIN.
REQ-019 outstanding SHALL update next cycle by +load_pop -load_response. Both in the same cycle SHALL leave it unchanged.
REQ-020 load_response with outstanding==0 SHALL be ignored (no underflow). The counter SHALL never exceed MAX_OUTSTANDING.
REQ-021 last_sub SHALL load load_subunit on load_pop and SHALL otherwise hold.
REQ-022 issue_sel SHALL be one-hot of load_subunit on load_pop, of store_subunit on store_pop, else zero.
REQ-023 Subunit indices >= NUM_SUBUNITS SHALL be treated as not ready.

Reset
REQ-024 While rst==0: state=NORMAL, outstanding=0, starve_cnt=0, last_sub=0, fence_ack=0, and load_pop=store_pop=0, issue_sel=0, regardless of inputs.
REQ-025 Reset asserted mid-operation (including mid-DRAIN or STORE_FORCE) SHALL abort immediately with no fence_ack. Deassertion SHALL take effect at the next clock edge.

Verification
REQ-026 Load and store valid, both subunits ready, NORMAL -> load_pop=1, store_pop=0, issue_sel=one-hot(load_subunit).
REQ-027 load_valid and store_valid held with all subunits ready, loads never blocked, MAX_OUTSTANDING=4 with load_response every cycle -> 8 load_pops, then STORE_FORCE, store_pop on the 9th cycle, NORMAL on the 10th.
REQ-028 4 loads popped to subunit 0 with no responses -> 5th load blocked (outstanding=4). One response -> load issues next cycle. load_subunit=1 with outstanding=1 -> blocked until outstanding=0.
REQ-029 fence_req=1 with outstanding=2 and 3 stores queued -> 3 store_pops, 0 load_pops. After 2 responses and sq_empty=1, fence_ack pulses once, then NORMAL.
REQ-030 load_pop and load_response in the same cycle at outstanding=3 -> stays 3. load_response at outstanding=0 -> stays 0.
REQ-031 rst=0 asynchronously during DRAIN with outstanding=2 -> outstanding=0, fence_ack=0, pops 0 immediately. First load after release issues normally.

Source files
------------

// File: rtl/lsq_issue_scheduler.sv
// Load/store queue issue scheduler.
// Picks at most one memory op per cycle (load or store) toward one of the
// memory subunits. Loads win by default. A starvation counter forces a store
// through after a run of load wins. A fence request drains outstanding loads
// and queued stores, then acknowledges with a one-cycle pulse.
module lsq_issue_scheduler #(
  parameter int NUM_SUBUNITS    = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8,
  localparam int SW = (NUM_SUBUNITS > 1) ? $clog2(NUM_SUBUNITS) : 1,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int TW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [SW-1:0]           load_subunit,
  input  logic                    store_valid,
  input  logic [SW-1:0]           store_subunit,
  input  logic [NUM_SUBUNITS-1:0] subunit_ready,
  input  logic                    load_response,
  input  logic                    sq_empty,
  input  logic                    fence_req,
  output logic                    load_pop,
  output logic                    store_pop,
  output logic [NUM_SUBUNITS-1:0] issue_sel,
  output logic [CW-1:0]           outstanding,
  output logic                    fence_ack
);

  typedef enum logic [1:0] {
    NORMAL,
    STORE_FORCE,
    DRAIN
  } state_e;

  state_e        state, state_nxt;
  logic [TW-1:0] starve_cnt, starve_nxt;
  logic [SW-1:0] last_sub;
  logic [CW-1:0] outstanding_nxt;
  logic          fence_ack_nxt;

  logic load_rdy, store_rdy;
  logic load_ok, store_ok;
  logic resp_take;
  logic drain_done;

  // Per-subunit ready lookup; out-of-range indices never match, so they read as not ready.
  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    load_rdy  = 1'b0;
    store_rdy = 1'b0;
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      if (load_subunit == SW'(i))  load_rdy  = subunit_ready[i];
      if (store_subunit == SW'(i)) store_rdy = subunit_ready[i];
    end
  end

  // A load may only follow loads to the same subunit so responses return in order.
  assign load_ok = load_valid & load_rdy
                 & (outstanding < CW'(MAX_OUTSTANDING))
                 & ((outstanding == '0) | (load_subunit == last_sub))
                 & (state == NORMAL);
  assign store_ok = store_valid & store_rdy;

  // Issue arbitration; reset holds both pops low regardless of inputs.
  always_comb begin
    load_pop  = 1'b0;
    store_pop = 1'b0;
    if (rst) begin
      if (state == NORMAL) begin
        load_pop  = load_ok;
        store_pop = store_ok & ~load_ok;
      end else begin
        store_pop = store_ok;
      end
    end
  end

  // One-hot target of whichever op issues this cycle.
  always_comb begin
    issue_sel = '0;
    for (int i = 0; i < NUM_SUBUNITS; i++) begin
      issue_sel[i] = (load_pop & (load_subunit == SW'(i)))
                   | (store_pop & (store_subunit == SW'(i)));
    end
  end

  // Counter next values: starvation run length and in-flight load count.
  assign resp_take = load_response & (outstanding != '0);
  always_comb begin
    starve_nxt = starve_cnt;
    if (store_pop | ~store_valid) begin
      starve_nxt = '0;
    end else if (store_ok & load_pop & (starve_cnt != TW'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + TW'(1);
    end

    outstanding_nxt = outstanding;
    if (load_pop & ~resp_take) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (~load_pop & resp_take) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  assign drain_done = (state == DRAIN) & sq_empty & (outstanding == '0) & ~store_pop;

  // Mode sequencing; a fence request overrides the starvation escape.
  always_comb begin
    state_nxt     = state;
    fence_ack_nxt = 1'b0;
    unique case (state)
      NORMAL: begin
        if (fence_req) begin
          state_nxt = DRAIN;
        end else if (starve_nxt == TW'(STARVE_LIMIT)) begin
          state_nxt = STORE_FORCE;
        end
      end
      STORE_FORCE: begin
        if (fence_req) begin
          state_nxt = DRAIN;
        end else if (store_pop | ~store_valid) begin
          state_nxt = NORMAL;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_nxt     = NORMAL;
          fence_ack_nxt = 1'b1;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  // State registers; asynchronous reset aborts any drain without an ack.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= NORMAL;
      starve_cnt  <= '0;
      outstanding <= '0;
      last_sub    <= '0;
      fence_ack   <= 1'b0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      outstanding <= outstanding_nxt;
      fence_ack   <= fence_ack_nxt;
      if (load_pop) last_sub <= load_subunit;
    end
  end

endmodule
